// File: rtl/tetris_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tetris_game_sequencer
// Brief    : 4x8 Tetris game controller; sequences piece generation, gravity,
//            moves and line-clear passes. Optional macro: SEQ_HARD_DROP_EN.
// Revision : 1.0
// ============================================================================
module tetris_game_sequencer #(
    parameter int LINES_W      = 8,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic               clka,
    input  logic               restart_n,
    input  logic               start,
    input  logic               drop_tick,
    input  logic               move_left,
    input  logic               move_right,
`ifdef SEQ_HARD_DROP_EN
    input  logic               hard_drop,
`endif
    input  logic [1:0]         piece_sel,
    output logic               clr_req,
    output logic [2:0]         clr_state,
    output logic [1:0]         clr_piece,
    output logic [31:0]        clr_board,
    input  logic               clr_done,
    input  logic [31:0]        clr_board_in,
    input  logic               clr_error,
    output logic [31:0]        board,
    output logic               game_over,
    output logic               fault,
    output logic [LINES_W-1:0] lines
);
    localparam int                 C_TMR_W    = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(WAIT_TIMEOUT - 1);
    localparam logic [31:0]        C_COL0     = 32'h1111_1111;
    localparam logic [31:0]        C_COL3     = 32'h8888_8888;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GEN      = 3'd1,
        S_WAIT_GEN = 3'd2,
        S_FALL     = 3'd3,
        S_CLEAR    = 3'd4,
        S_WAIT_CLR = 3'd5,
        S_OVER     = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        board_q, board_d;
    logic [31:0]        mask_q, mask_d;
    logic [LINES_W-1:0] lines_q, lines_d;
    logic [C_TMR_W-1:0] tmr_q, tmr_d;
    logic [1:0]         piece_q, piece_d;
    logic [2:0]         phase_q, phase_d;
    logic               req_q, req_d;
    logic               over_q, over_d;
    logic               fault_q, fault_d;

    logic [31:0]        w_rest, w_down, w_left, w_right, w_spawn;
    logic               w_down_ok, w_left_ok, w_right_ok;
    logic [7:0]         w_full;
    logic [2:0]         w_bot;
    logic               w_any, w_two, w_hard;
    logic [LINES_W:0]   w_sum;
    logic [LINES_W-1:0] w_lines_sat;

`ifdef SEQ_HARD_DROP_EN
    logic hard_q, hard_d;
    assign w_hard = hard_q | hard_drop;
`else
    assign w_hard = 1'b0;
`endif

    // Settled cells are the board minus the active piece.
    assign w_rest     = board_q & ~mask_q;
    assign w_down     = mask_q << 4;
    assign w_left     = mask_q >> 1;
    assign w_right    = mask_q << 1;
    assign w_down_ok  = (mask_q[31:28] == 4'h0) && ((w_down & w_rest) == 32'h0);
    assign w_left_ok  = ((mask_q & C_COL0) == 32'h0) && ((w_left & w_rest) == 32'h0);
    assign w_right_ok = ((mask_q & C_COL3) == 32'h0) && ((w_right & w_rest) == 32'h0);

    always_comb begin
        case (piece_q)
            2'b00:   w_spawn = 32'h0000_0002;
            2'b01:   w_spawn = 32'h0000_0006;
            2'b10:   w_spawn = 32'h0000_0066;
            default: w_spawn = 32'h0000_0062;
        endcase
    end

    always_comb begin
        w_any = 1'b0;
        w_bot = 3'd0;
        for (int r = 0; r < 8; r++) begin
            w_full[r] = &board_q[r*4 +: 4];
            if (w_full[r]) begin
                w_any = 1'b1;
                w_bot = 3'(r);
            end
        end
        w_two = (w_bot != 3'd0) && w_full[w_bot - 3'd1];
    end

    // One extra bit catches the carry; the increment is at most 2.
    assign w_sum       = {1'b0, lines_q} + (LINES_W+1)'(w_two ? 2 : 1);
    assign w_lines_sat = w_sum[LINES_W] ? {LINES_W{1'b1}} : w_sum[LINES_W-1:0];

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        mask_d  = mask_q;
        lines_d = lines_q;
        tmr_d   = tmr_q;
        piece_d = piece_q;
        phase_d = phase_q;
        req_d   = 1'b0;
        over_d  = over_q;
        fault_d = fault_q;
`ifdef SEQ_HARD_DROP_EN
        hard_d  = hard_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_GEN;
            end
            S_GEN: begin
                piece_d = piece_sel;
                phase_d = 3'd0;
                req_d   = 1'b1;
                tmr_d   = '0;
                state_d = S_WAIT_GEN;
            end
            S_WAIT_GEN: begin
                tmr_d = tmr_q + 1'b1;
                if (clr_done) begin
                    if (clr_error) begin
                        over_d  = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        board_d = clr_board_in;
                        mask_d  = w_spawn;
                        state_d = S_FALL;
                    end
                end else if (tmr_q == C_TMR_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_OVER;
                end
            end
            S_FALL: begin
                if (w_hard || drop_tick) begin
                    if (w_down_ok) begin
                        mask_d  = w_down;
                        board_d = w_rest | w_down;
                    end else begin
                        mask_d  = '0;
                        state_d = S_CLEAR;
                    end
`ifdef SEQ_HARD_DROP_EN
                    hard_d = w_hard && w_down_ok;
`endif
                end else if (move_left && !move_right) begin
                    if (w_left_ok) begin
                        mask_d  = w_left;
                        board_d = w_rest | w_left;
                    end
                end else if (move_right && !move_left) begin
                    if (w_right_ok) begin
                        mask_d  = w_right;
                        board_d = w_rest | w_right;
                    end
                end
            end
            S_CLEAR: begin
                if (w_any) begin
                    lines_d = w_lines_sat;
                    phase_d = 3'd1;
                    req_d   = 1'b1;
                    tmr_d   = '0;
                    state_d = S_WAIT_CLR;
                end else begin
                    state_d = S_GEN;
                end
            end
            S_WAIT_CLR: begin
                tmr_d = tmr_q + 1'b1;
                if (clr_done) begin
                    board_d = clr_board_in;
                    state_d = S_CLEAR;
                end else if (tmr_q == C_TMR_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_OVER;
                end
            end
            S_OVER: begin
                if (start) begin
                    board_d = '0;
                    mask_d  = '0;
                    lines_d = '0;
                    over_d  = 1'b0;
                    fault_d = 1'b0;
                    state_d = S_GEN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            state_q <= S_IDLE;
            board_q <= '0;
            mask_q  <= '0;
            lines_q <= '0;
            tmr_q   <= '0;
            piece_q <= 2'b00;
            phase_q <= 3'd1;
            req_q   <= 1'b0;
            over_q  <= 1'b0;
            fault_q <= 1'b0;
`ifdef SEQ_HARD_DROP_EN
            hard_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            mask_q  <= mask_d;
            lines_q <= lines_d;
            tmr_q   <= tmr_d;
            piece_q <= piece_d;
            phase_q <= phase_d;
            req_q   <= req_d;
            over_q  <= over_d;
            fault_q <= fault_d;
`ifdef SEQ_HARD_DROP_EN
            hard_q  <= hard_d;
`endif
        end
    end

    assign clr_req   = req_q;
    assign clr_state = phase_q;
    assign clr_piece = piece_q;
    assign clr_board = board_q;
    assign board     = board_q;
    assign game_over = over_q;
    assign fault     = fault_q;
    assign lines     = lines_q;

endmodule
`default_nettype wire

// File: tb/tb_tetris_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_game_sequencer
// Brief    : Self-checking bench with a cell-level game model and a model of
//            the clear/redraw block.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_tetris_game_sequencer;
    localparam int LW   = 2;
    localparam int LSAT = 3;

    logic        clka = 1'b0;
    logic        restart_n = 1'b1;
    logic        start = 1'b0, drop_tick = 1'b0, move_left = 1'b0, move_right = 1'b0;
    logic [1:0]  piece_sel = 2'b00;
    logic        clr_req;
    logic [2:0]  clr_state;
    logic [1:0]  clr_piece;
    logic [31:0] clr_board;
    logic        clr_done = 1'b0;
    logic [31:0] clr_board_in = 32'h0;
    logic        clr_error = 1'b0;
    logic [31:0] board;
    logic        game_over, fault;
    logic [LW-1:0] lines;
`ifdef SEQ_HARD_DROP_EN
    logic        hard_drop = 1'b0;
`endif

    tetris_game_sequencer #(.LINES_W(LW), .WAIT_TIMEOUT(15)) dut (
        .clka(clka), .restart_n(restart_n), .start(start),
        .drop_tick(drop_tick), .move_left(move_left), .move_right(move_right),
`ifdef SEQ_HARD_DROP_EN
        .hard_drop(hard_drop),
`endif
        .piece_sel(piece_sel), .clr_req(clr_req), .clr_state(clr_state),
        .clr_piece(clr_piece), .clr_board(clr_board), .clr_done(clr_done),
        .clr_board_in(clr_board_in), .clr_error(clr_error), .board(board),
        .game_over(game_over), .fault(fault), .lines(lines)
    );

    always #5 clka = ~clka;

    int total = 0;
    int bad   = 0;

    // Game model: settled rows (bit c = column c) plus a list of piece cells.
    logic [3:0] srow [8];
    int  pr [4];
    int  pc [4];
    int  pn = 0;
    int  m_lines = 0;
    bit  m_go = 0;
    bit  locked = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clka);
        #1;
    endtask

    function automatic logic [31:0] mword();
        logic [31:0] w;
        w = '0;
        for (int r = 0; r < 8; r++) w[r*4 +: 4] = srow[r];
        for (int i = 0; i < pn; i++) w[pr[i]*4 + pc[i]] = 1'b1;
        return w;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) srow[r] = 4'h0;
        pn = 0; m_lines = 0; m_go = 0;
    endtask

    task automatic set_spawn(input logic [1:0] sel);
        case (sel)
            2'b00: begin pn = 1; pr[0] = 0; pc[0] = 1; end
            2'b01: begin pn = 2; pr[0] = 0; pc[0] = 1; pr[1] = 0; pc[1] = 2; end
            2'b10: begin pn = 4; pr[0] = 0; pc[0] = 1; pr[1] = 0; pc[1] = 2;
                                 pr[2] = 1; pc[2] = 1; pr[3] = 1; pc[3] = 2; end
            default: begin pn = 3; pr[0] = 0; pc[0] = 1; pr[1] = 1; pc[1] = 1;
                                   pr[2] = 1; pc[2] = 2; end
        endcase
    endtask

    function automatic bit fits(input int dr, input int dc);
        for (int i = 0; i < pn; i++) begin
            int nr, nc;
            nr = pr[i] + dr;
            nc = pc[i] + dc;
            if (nr < 0 || nr > 7 || nc < 0 || nc > 3) return 1'b0;
            if (srow[nr][nc]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit any_full();
        for (int r = 0; r < 8; r++) if (srow[r] == 4'hF) return 1'b1;
        return 1'b0;
    endfunction

    // Clears the bottom-most full row (and the one above if also full), shifting down.
    task automatic clear_pass();
        int r, n;
        r = 0;
        for (int k = 0; k < 8; k++) if (srow[k] == 4'hF) r = k;
        n = (r > 0 && srow[r-1] == 4'hF) ? 2 : 1;
        for (int k = r; k >= 0; k--) srow[k] = (k - n >= 0) ? srow[k-n] : 4'h0;
        m_lines = (m_lines + n > LSAT) ? LSAT : m_lines + n;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (clr_req) begin seen = 1'b1; break; end
            cyc();
        end
        check("req_seen", {31'h0, seen}, 32'h1);
    endtask

    task automatic serve(input bit force_err, input logic [31:0] preload, input int delay);
        bit seen, err;
        logic [31:0] resp;
        logic [3:0] sav [8];
        wait_req(seen);
        if (!seen) return;
        err = 1'b0;
        if (any_full()) begin
            check("clr_state_clear", {29'h0, clr_state}, 32'h1);
            check("clr_board", clr_board, mword());
            clear_pass();
            check("lines_at_req", {30'h0, lines}, m_lines);
        end else begin
            check("clr_state_gen", {29'h0, clr_state}, 32'h0);
            check("clr_piece", {30'h0, clr_piece}, {30'h0, piece_sel});
            for (int r = 0; r < 8; r++) begin
                sav[r] = srow[r];
                srow[r] = srow[r] | preload[r*4 +: 4];
            end
            set_spawn(piece_sel);
            err = force_err || !fits(0, 0);
            if (err) begin
                pn = 0;
                m_go = 1'b1;
                for (int r = 0; r < 8; r++) srow[r] = sav[r];
            end
        end
        resp = mword();
        for (int k = 0; k < delay; k++) begin
            cyc();
            check("req_one_cycle", {31'h0, clr_req}, 32'h0);
        end
        clr_done = 1'b1; clr_board_in = resp; clr_error = err;
        cyc();
        clr_done = 1'b0; clr_error = 1'b0; clr_board_in = $urandom;
        check("board_after_done", board, mword());
        check("game_over", {31'h0, game_over}, {31'h0, m_go});
        check("fault_clear", {31'h0, fault}, 32'h0);
    endtask

    task automatic settle(input bit force_err, input logic [31:0] preload, output int passes);
        bit was_clear;
        passes = 0;
        for (int k = 0; k < 12; k++) begin
            was_clear = any_full();
            serve(force_err, preload, $urandom_range(1, 4));
            if (!was_clear) break;
            passes++;
        end
    endtask

    task automatic fall_step(input bit d, input bit l, input bit r);
        drop_tick = d; move_left = l; move_right = r;
        start = ($urandom_range(0, 9) == 0);
        cyc();
        drop_tick = 1'b0; move_left = 1'b0; move_right = 1'b0; start = 1'b0;
        if (d) begin
            if (fits(1, 0)) begin
                for (int i = 0; i < pn; i++) pr[i]++;
            end else begin
                for (int i = 0; i < pn; i++) srow[pr[i]][pc[i]] = 1'b1;
                pn = 0;
                locked = 1'b1;
            end
        end else if (l ^ r) begin
            if (fits(0, l ? -1 : 1)) for (int i = 0; i < pn; i++) pc[i] += (l ? -1 : 1);
        end
        check("fall_board", board, mword());
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int np;
        model_reset();
        #2 restart_n = 1'b0;
        cyc(); cyc();
        check("rst_board", board, 32'h0);
        check("rst_lines", {30'h0, lines}, 32'h0);
        check("rst_req", {31'h0, clr_req}, 32'h0);
        check("rst_state", {29'h0, clr_state}, 32'h1);
        check("rst_piece", {30'h0, clr_piece}, 32'h0);
        check("rst_over", {31'h0, game_over}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        restart_n = 1'b1;
        cyc();

        // Single piece falls to the floor on an empty board.
        piece_sel = 2'b00;
        start_pulse();
        serve(1'b0, 32'h0, 2);
        check("s1_spawn", board, 32'h0000_0002);
        for (int i = 0; i < 7; i++) fall_step(1, 0, 0);
        check("s1_bottom", board, 32'h2000_0000);
        fall_step(1, 0, 0);
        check("s1_locked", {31'h0, locked}, 32'h1);
        locked = 1'b0;

        // Preloaded bottom row completed by a single moved left.
        settle(1'b0, 32'hE000_0000, np);
        check("s1_passes", np, 0);
        check("s1_lines", {30'h0, lines}, 32'h0);
        check("s2_spawn", board, 32'hE000_0002);
        fall_step(0, 1, 0);
        check("s2_left", board, 32'hE000_0001);
        for (int i = 0; i < 7; i++) fall_step(1, 0, 0);
        check("s2_full", board, 32'hF000_0000);
        piece_sel = 2'b10;
        fall_step(1, 0, 0);
        locked = 1'b0;

        // Square lands on a full row making three full rows: two passes, lines saturate.
        settle(1'b0, 32'hF990_0000, np);
        check("s2_passes", np, 1);
        check("s3_spawn", board, 32'hF990_0066);
        for (int i = 0; i < 6; i++) fall_step(1, 0, 0);
        check("s3_lock_board", board, 32'hFFF0_0000);
        locked = 1'b0;
        settle(1'b1, 32'h0, np);
        check("s3_passes", np, 2);
        check("s3_lines_sat", {30'h0, lines}, 32'h3);
        check("s4_over", {31'h0, game_over}, 32'h1);

        // Restart from game over.
        start_pulse();
        model_reset();
        check("s4_board_clr", board, 32'h0);
        check("s4_lines_clr", {30'h0, lines}, 32'h0);
        serve(1'b0, 32'h0, 3);
        check("s6_spawn", board, 32'h0000_0066);
        fall_step(0, 1, 0);
        check("s6_left", board, 32'h0000_0033);
        fall_step(0, 1, 0);
        check("s6_wall", board, 32'h0000_0033);
        fall_step(1, 0, 1);
        check("s6_drop_prio", board, 32'h0000_0330);
        fall_step(0, 1, 1);
        check("s6_both", board, 32'h0000_0330);

        // Random play against the model.
        for (int p = 0; p < 60; p++) begin
            if (m_go) begin
                piece_sel = 2'($urandom_range(0, 3));
                start_pulse();
                model_reset();
                settle(1'b0, 32'h0, np);
                continue;
            end
            piece_sel = 2'($urandom_range(0, 3));
            locked = 1'b0;
            for (int s = 0; s < 200 && !locked; s++) begin
                int a;
                a = $urandom_range(0, 9);
                fall_step(a < 3 || a == 9 || s > 150, a == 3 || a == 4 || a == 8 || a == 9,
                          a == 5 || a == 6 || a == 8);
            end
            check("rand_locked", {31'h0, locked}, 32'h1);
            settle(1'b0, 32'h0, np);
        end

        // Timeout on the next request.
        if (m_go) begin
            start_pulse();
            model_reset();
        end else begin
            locked = 1'b0;
            for (int s = 0; s < 20 && !locked; s++) fall_step(1, 0, 0);
        end
        wait_req(seen);
        repeat (14) cyc();
        check("no_fault_early", {31'h0, fault}, 32'h0);
        cyc();
        check("fault_timeout", {31'h0, fault}, 32'h1);
        check("timeout_no_over", {31'h0, game_over}, 32'h0);

        // Asynchronous restart in the middle of a clear wait.
        start_pulse();
        model_reset();
        piece_sel = 2'b00;
        serve(1'b0, 32'hE000_0000, 2);
        check("r_spawn", board, 32'hE000_0002);
        fall_step(0, 1, 0);
        for (int i = 0; i < 8; i++) fall_step(1, 0, 0);
        wait_req(seen);
        check("r_clear_phase", {29'h0, clr_state}, 32'h1);
        check("r_lines", {30'h0, lines}, 32'h1);
        cyc(); cyc();
        #2 restart_n = 1'b0;
        #1;
        check("ar_board", board, 32'h0);
        check("ar_lines", {30'h0, lines}, 32'h0);
        check("ar_state", {29'h0, clr_state}, 32'h1);
        check("ar_req", {31'h0, clr_req}, 32'h0);
        check("ar_fault", {31'h0, fault}, 32'h0);
        clr_done = 1'b1; clr_board_in = 32'hFFFF_FFFF;
        cyc();
        clr_done = 1'b0;
        restart_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("idle_no_req", {31'h0, clr_req}, 32'h0);
        end
        check("late_done_ignored", board, 32'h0);
        model_reset();
        piece_sel = 2'b11;
        start_pulse();
        serve(1'b0, 32'h0, 1);
        check("l_spawn", board, 32'h0000_0062);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tetris_game_sequencer.md
Name: tetris_game_sequencer

Overview:
- Top-level game controller for the 4x8 Tetris board; owns the settled-board register and the active-piece mask.
- Sequences the clear/redraw datapath: requests piece generation (phase 0) and line-clear passes (phase nonzero), and loops clear passes until no full row remains.
- Applies gravity ticks and left/right moves with wall and collision checks, then raises game_over on spawn collision.
- Sits between input debouncers/tick divider and the clear/redraw block.

Parameters:
LINES_W, 8, width of cleared-lines counter (saturating)
WAIT_TIMEOUT, 15, max cycles waiting for clr_done before fault

Ports:
clka  input  1  system clock, rising edge
restart_n  input  1  asynchronous active-low reset
start  input  1  1-cycle pulse: begin/restart game
drop_tick  input  1  1-cycle gravity pulse
move_left  input  1  1-cycle pulse
move_right  input  1  1-cycle pulse
piece_sel  input  2  next piece code (00 single, 01 horiz pair, 10 square, 11 L)
clr_req  output  1  1-cycle request to clear/redraw block
clr_state  output  3  phase to clear block: 0=GEN, 1=CLEAR
clr_piece  output  2  piece code latched at GEN
clr_board  output  32  board sent to clear block (= board reg)
clr_done  input  1  clear block result valid (1 cycle)
clr_board_in  input  32  result board
clr_error  input  1  spawn collision flag
board  output  32  current board incl. active piece
game_over  output  1  sticky until start
fault  output  1  sticky: clr_done timeout
lines  output  LINES_W  cleared rows, saturating

Behaviour:
- Board bit = row*4+col; row 0 = top (bits 3:0), row 7 = bottom (bits 31:28). Down = mask<<4.
- Reset: state IDLE; board, piece mask, lines, clr_piece = 0; clr_req, game_over, fault = 0; clr_state = 1.
- States: IDLE, GEN, WAIT_GEN, FALL, CLEAR, WAIT_CLR, OVER.
- IDLE: start -> GEN.
- GEN (1 cycle): clr_piece <= piece_sel; clr_state = 0; clr_req = 1 -> WAIT_GEN.
- WAIT_GEN: on clr_done: if clr_error, set game_over -> OVER. Otherwise board <= clr_board_in, and mask <= spawn mask (00:0x2, 01:0x6, 10:0x66, 11:0x62) -> FALL.
- FALL, one action per cycle; drop_tick has priority over moves; left and right together are ignored.
  - Down is legal if mask[31:28]==0 and (mask<<4) & (board & ~mask) == 0.
  - Left is illegal if the mask occupies col 0; right is illegal if it occupies col 3. Both also require no collision.
  - A legal move updates mask and board together in the same cycle.
  - An illegal drop locks the piece (mask <= 0) -> CLEAR.
- CLEAR: if board has no full row -> GEN. Otherwise:
  - n = 2 if the bottom-most full row r and row r-1 are both full, else 1.
  - lines += n, saturating at all-ones.
  - clr_state = 1, clr_req = 1 -> WAIT_CLR.
- WAIT_CLR: on clr_done, board <= clr_board_in -> CLEAR (re-check).
- WAIT_GEN/WAIT_CLR: counter reset on entry. If WAIT_TIMEOUT cycles elapse without clr_done, set fault -> OVER.
- OVER: hold board. start -> board, lines, game_over, fault cleared -> GEN.
- start in any state other than IDLE/OVER is ignored.
- restart_n low at any time, including mid-WAIT_CLR, returns to reset values immediately. A late clr_done after reset is ignored in IDLE.
- clr_req is exactly 1 cycle per request; no new request until clr_done or timeout.

Optional Feature:
SEQ_HARD_DROP_EN
- Defined: adds input hard_drop (1-cycle pulse). In FALL it starts a hard drop:
  - Piece moves down one row per cycle until blocked, then locks -> CLEAR.
  - drop_tick, move_left and move_right are ignored during the hard drop.
- Undefined: port absent; behaviour as above.

Test Plan:
- Empty board, start, piece_sel=00, clr_done 2 cycles after clr_req, 7 drop_ticks -> board=0x20000000. 8th tick -> lock, CLEAR sees no full row -> GEN; lines=0.
- Preload bottom row 0xE0000000, piece 00, move_left once (mask 0x1), 7 ticks -> board 0xF0000000. 8th tick -> clr_req with clr_state=1; clear block returns 0 -> board=0, lines=1.
- Bottom two rows full after lock -> lines+=2 with one clr_req. Third full row above -> a second pass is issued, lines=3.
- clr_error=1 on GEN response -> game_over=1, state OVER; start -> board=0, lines=0, new clr_req with clr_state=0.
- No clr_done for 15 cycles after clr_req -> fault=1, OVER. Then restart_n low during WAIT_CLR -> all outputs at reset values next cycle.
- Piece 10 at col 0-1: move_left -> no change. drop_tick and move_right in the same cycle -> only the drop is applied.
